// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer,
// bubble-masked control bits, flush and a saturating drop counter.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] head_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              accept;
    logic              issue;
    logic              ld_head_in;
    logic              ld_head_skid;
    logic              ld_skid;
    logic [2:0]        drop_inc;
    logic [CNT_W:0]    drop_sum;
    logic [CNT_W-1:0]  drop_next;

    assign accept    = in_valid && in_ready;
    assign issue     = out_valid && out_ready;
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign out_ctrl  = out_valid ? head_ctrl : '0;
    assign out_data  = head_data;

    always_comb begin
        state_d      = state_q;
        ld_head_in   = 1'b0;
        ld_head_skid = 1'b0;
        ld_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d    = ONE;
                    ld_head_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && issue) begin
                    ld_head_in = 1'b1;
                end else if (accept) begin
                    if (SKID != 0) begin
                        state_d = FULL;
                        ld_skid = 1'b1;
                    end
                end else if (issue) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (issue) begin
                    state_d      = ONE;
                    ld_head_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flushed entries never reach the head, so out_data keeps the last real head.
        if (flush) begin
            state_d      = EMPTY;
            ld_head_in   = 1'b0;
            ld_head_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    // Issue implies occupancy >= 1, so the increment never underflows.
    always_comb begin
        drop_inc  = {1'b0, occupancy} + {2'b00, accept} - {2'b00, issue};
        drop_sum  = {1'b0, drop_cnt} + (CNT_W+1)'(drop_inc);
        drop_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            head_data <= '0;
            head_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
            drop_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (ld_head_in) begin
                head_data <= in_data;
                head_ctrl <= in_ctrl;
            end else if (ld_head_skid) begin
                head_data <= skid_data;
                head_ctrl <= skid_ctrl;
            end
            if (ld_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
            if (flush) begin
                drop_cnt <= drop_next;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic ready_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (state_d != FULL);
                end
            end
            assign in_ready = ready_q;
        end else begin : g_noskid
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table on the skid variant,
// saturation on a narrow counter, random queue check on the no-skid variant.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Main DUT: defaults (SKID=1, CNT_W=16)
    logic        m_iv, m_ir, m_fl, m_ov, m_ordy;
    logic [3:0]  m_ic, m_oc;
    logic [31:0] m_id, m_od;
    logic [1:0]  m_occ;
    logic [15:0] m_dc;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset),
        .in_valid(m_iv), .in_ready(m_ir),
        .in_ctrl(m_ic), .in_data(m_id),
        .flush(m_fl),
        .out_valid(m_ov), .out_ready(m_ordy),
        .out_ctrl(m_oc), .out_data(m_od),
        .occupancy(m_occ), .drop_cnt(m_dc)
    );

    // Narrow-counter DUT
    logic        c_iv, c_ir, c_fl, c_ov, c_ordy;
    logic [3:0]  c_ic, c_oc;
    logic [31:0] c_id, c_od;
    logic [1:0]  c_occ;
    logic [1:0]  c_dc;

    pipe_stage_reg #(.CNT_W(2)) dut_c (
        .clk(clk), .reset(reset),
        .in_valid(c_iv), .in_ready(c_ir),
        .in_ctrl(c_ic), .in_data(c_id),
        .flush(c_fl),
        .out_valid(c_ov), .out_ready(c_ordy),
        .out_ctrl(c_oc), .out_data(c_od),
        .occupancy(c_occ), .drop_cnt(c_dc)
    );

    // Single-entry DUT
    logic        z_iv, z_ir, z_fl, z_ov, z_ordy;
    logic [3:0]  z_ic, z_oc;
    logic [31:0] z_id, z_od;
    logic [1:0]  z_occ;
    logic [15:0] z_dc;

    pipe_stage_reg #(.SKID(0)) dut_z (
        .clk(clk), .reset(reset),
        .in_valid(z_iv), .in_ready(z_ir),
        .in_ctrl(z_ic), .in_data(z_id),
        .flush(z_fl),
        .out_valid(z_ov), .out_ready(z_ordy),
        .out_ctrl(z_oc), .out_data(z_od),
        .occupancy(z_occ), .drop_cnt(z_dc)
    );

    typedef struct {
        logic        iv;
        logic [3:0]  ic;
        logic [31:0] id;
        logic        ordy;
        logic        fl;
        logic        eov;
        logic [3:0]  eoc;
        logic [31:0] eod;
        logic        eir;
        logic [1:0]  eocc;
        logic [15:0] edc;
    } vec_t;

    vec_t vecs[15];
    logic [35:0] q[$];

    function automatic vec_t mk(
        logic iv, logic [3:0] ic, logic [31:0] id, logic ordy, logic fl,
        logic eov, logic [3:0] eoc, logic [31:0] eod, logic eir,
        logic [1:0] eocc, logic [15:0] edc);
        vec_t v;
        v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
        v.eov = eov; v.eoc = eoc; v.eod = eod; v.eir = eir;
        v.eocc = eocc; v.edc = edc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 100)
                $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic eov,
                            input logic [3:0] eoc, input logic [31:0] eod,
                            input logic eir, input logic [1:0] eocc,
                            input logic [15:0] edc);
        chk({tag, "_ov"}, 64'(m_ov), 64'(eov));
        chk({tag, "_oc"}, 64'(m_oc), 64'(eoc));
        chk({tag, "_od"}, 64'(m_od), 64'(eod));
        chk({tag, "_ir"}, 64'(m_ir), 64'(eir));
        chk({tag, "_occ"}, 64'(m_occ), 64'(eocc));
        chk({tag, "_dc"}, 64'(m_dc), 64'(edc));
    endtask

    initial begin
        vecs[0]  = mk(1, 4'hF, 32'h10, 1, 0, 1, 4'hF, 32'h10, 1, 1, 0);
        vecs[1]  = mk(0, 4'h0, 32'h0,  1, 0, 0, 4'h0, 32'h10, 1, 0, 0);
        vecs[2]  = mk(1, 4'h1, 32'h1,  0, 0, 1, 4'h1, 32'h1,  1, 1, 0);
        vecs[3]  = mk(1, 4'h2, 32'h2,  0, 0, 1, 4'h1, 32'h1,  0, 2, 0);
        vecs[4]  = mk(0, 4'h0, 32'h0,  1, 0, 1, 4'h2, 32'h2,  1, 1, 0);
        vecs[5]  = mk(0, 4'h0, 32'h0,  1, 0, 0, 4'h0, 32'h2,  1, 0, 0);
        vecs[6]  = mk(1, 4'h3, 32'h3,  0, 0, 1, 4'h3, 32'h3,  1, 1, 0);
        vecs[7]  = mk(1, 4'h4, 32'h4,  0, 0, 1, 4'h3, 32'h3,  0, 2, 0);
        vecs[8]  = mk(0, 4'h0, 32'h0,  0, 1, 0, 4'h0, 32'h3,  1, 0, 2);
        vecs[9]  = mk(1, 4'h5, 32'h5,  0, 0, 1, 4'h5, 32'h5,  1, 1, 2);
        vecs[10] = mk(1, 4'h6, 32'h6,  1, 1, 0, 4'h0, 32'h5,  1, 0, 3);
        vecs[11] = mk(1, 4'h7, 32'h7,  1, 0, 1, 4'h7, 32'h7,  1, 1, 3);
        vecs[12] = mk(1, 4'h8, 32'h8,  1, 0, 1, 4'h8, 32'h8,  1, 1, 3);
        vecs[13] = mk(0, 4'h0, 32'h0,  0, 0, 1, 4'h8, 32'h8,  1, 1, 3);
        vecs[14] = mk(0, 4'h0, 32'h0,  1, 0, 0, 4'h0, 32'h8,  1, 0, 3);

        reset = 1'b1;
        m_iv = 0; m_ic = 0; m_id = 0; m_ordy = 0; m_fl = 0;
        c_iv = 0; c_ic = 0; c_id = 0; c_ordy = 0; c_fl = 0;
        z_iv = 0; z_ic = 0; z_id = 0; z_ordy = 0; z_fl = 0;
        step();
        step();
        chk_main("rst", 0, 4'h0, 32'h0, 1, 0, 0);
        chk("rst_z_ir", 64'(z_ir), 64'(1));
        chk("rst_c_dc", 64'(c_dc), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            m_iv = vecs[i].iv; m_ic = vecs[i].ic; m_id = vecs[i].id;
            m_ordy = vecs[i].ordy; m_fl = vecs[i].fl;
            step();
            chk_main($sformatf("v%0d", i), vecs[i].eov, vecs[i].eoc,
                     vecs[i].eod, vecs[i].eir, vecs[i].eocc, vecs[i].edc);
        end

        // Reset mid-operation beats a simultaneous flush and handshakes
        m_iv = 1; m_ic = 4'h9; m_id = 32'h9; m_ordy = 0; m_fl = 0;
        step();
        m_ic = 4'hA; m_id = 32'hA;
        step();
        chk("pre_rst_occ", 64'(m_occ), 64'(2));
        reset = 1; m_fl = 1; m_ordy = 1; m_ic = 4'hB; m_id = 32'hB;
        step();
        chk_main("midrst", 0, 4'h0, 32'h0, 1, 0, 0);
        reset = 0; m_fl = 0; m_ordy = 0;
        m_iv = 1; m_ic = 4'h1; m_id = 32'h55;
        step();
        chk_main("post_rst", 1, 4'h1, 32'h55, 1, 1, 0);
        m_iv = 0; m_ordy = 1;
        step();
        chk("drain_ov", 64'(m_ov), 64'(0));
        m_ordy = 0;

        // Narrow counter saturates at 3
        for (int k = 0; k < 4; k++) begin
            c_iv = 1; c_ic = 4'h3; c_id = 32'(k); c_fl = 1;
            step();
            chk($sformatf("sat%0d", k), 64'(c_dc), 64'((k < 3) ? k + 1 : 3));
            chk($sformatf("sat%0d_ov", k), 64'(c_ov), 64'(0));
        end
        c_iv = 0; c_fl = 0;

        // Single-entry variant against a reference queue
        for (int n = 0; n < 10000; n++) begin
            logic acc;
            logic iss;
            z_iv = 1'($urandom_range(0, 1));
            z_ordy = 1'($urandom_range(0, 1));
            z_ic = 4'($urandom);
            z_id = $urandom;
            #1;
            chk("z_ir", 64'(z_ir), 64'(!z_ov || z_ordy));
            acc = z_iv && z_ir;
            iss = z_ov && z_ordy;
            if (iss) begin
                if (q.size() == 0) begin
                    chk("z_spurious", 64'(1), 64'(0));
                end else begin
                    chk("z_data", {28'h0, z_oc, z_od}, 64'(q[0]));
                    void'(q.pop_front());
                end
            end
            if (!z_ov) chk("z_ctrl_bubble", 64'(z_oc), 64'(0));
            if (acc) q.push_back({z_ic, z_id});
            step();
            chk("z_occ_le1", 64'(z_occ <= 2'd1), 64'(1));
            chk("z_ov", 64'(z_ov), 64'(q.size() != 0));
        end
        z_iv = 0;
        chk("z_dc", 64'(z_dc), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: payload width; the payload is held across bubbles.
REQ-002 Parameter CTRL_W, default 4: control-bit width; control bits are forced to zero on bubbles (e.g. reg/mem write enables).
REQ-003 Parameter SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
REQ-004 Parameter CNT_W, default 16: width of the flush-drop counter.
REQ-005 Port clk, input, 1: clock; reset, synchronous, active-high; clock clk.
REQ-006 Port reset, input, 1: synchronous active-high reset.
REQ-007 Port in_valid, input, 1: upstream entry present.
REQ-008 Port in_ready, output, 1: stage can accept an entry.
REQ-009 Port in_ctrl, input, CTRL_W: upstream control bits.
REQ-010 Port in_data, input, DATA_W: upstream payload.
REQ-011 Port flush, input, 1: discard all held entries and the same-cycle input.
REQ-012 Port out_valid, output, 1: entry presented downstream.
REQ-013 Port out_ready, input, 1: downstream accepts.
REQ-014 Port out_ctrl, output, CTRL_W: control bits of the head entry.
REQ-015 Port out_data, output, DATA_W: payload of the head entry.
REQ-016 Port occupancy, output, 2: number of entries held (0..2).
REQ-017 Port drop_cnt, output, CNT_W: saturating count of entries discarded by flush.

Function
REQ-018 An accept SHALL occur when in_valid && in_ready; an issue SHALL occur when out_valid && out_ready.
REQ-019 Entries SHALL issue in accept order with no loss or duplication, except on flush.
REQ-020 Latency SHALL be 1 cycle: an entry accepted into an empty stage appears with out_valid=1 on the next edge.
REQ-021 Occupancy SHALL follow the states EMPTY(0), ONE(1) and FULL(2); FULL is reachable only when SKID=1.
REQ-022 State transitions SHALL be: EMPTY+accept -> ONE; ONE+accept, no issue -> FULL; ONE+issue, no accept -> EMPTY; ONE+accept+issue -> ONE (head replaced by new entry); FULL+issue -> ONE (skid entry moves to head); all other cases hold state.
REQ-023 With SKID=1, in_ready SHALL be a register equal to (next state != FULL); in FULL it is 0, so no accept can occur in the FULL cycle.
REQ-024 With SKID=0, in_ready SHALL equal !out_valid || out_ready (combinational), and the depth is 1.
REQ-025 out_valid SHALL equal (occupancy != 0).
REQ-026 out_ctrl SHALL be all-zero whenever out_valid=0.
REQ-027 out_data SHALL retain the last head payload when out_valid=0.
REQ-028 Flush SHALL force the next state to EMPTY, including a same-cycle accept.
REQ-029 Flush SHALL NOT gate in_ready, so a same-cycle handshake completes and that entry is dropped.
REQ-030 Flush SHALL NOT clear the data registers.
REQ-031 Under flush, an issue handshake in the same cycle still counts as delivered to downstream.
REQ-032 On flush, drop_cnt SHALL increase by (occupancy − issued_this_cycle + accepted_this_cycle) and saturate at 2^CNT_W−1, with no wrap-around.
REQ-033 drop_cnt SHALL be unaffected by issues and accepts that occur without flush.

Reset
REQ-034 When reset=1 at a clk edge, next-state values SHALL be: occupancy=0, out_valid=0, out_ctrl=0, out_data=0, skid entry=0, drop_cnt=0, and in_ready=1 (SKID=1).
REQ-035 Reset SHALL take priority over flush and all handshakes.
REQ-036 Reset asserted mid-operation SHALL discard held entries without incrementing drop_cnt.
REQ-037 After reset deassertion, an accept SHALL be possible on the first cycle.

Verification
REQ-038 SKID=1: reset, then in_valid=1, in_ctrl=4'hF, in_data=32'h0000_0010 with out_ready=1 for 1 cycle -> next cycle out_valid=1, out_ctrl=4'hF, out_data=32'h10; following cycle out_valid=0, out_ctrl=0, out_data=32'h10.
REQ-039 SKID=1: accept A=1, B=2 with out_ready=0 -> occupancy=2 and in_ready=0; then raise out_ready -> A then B issue on consecutive cycles, and in_ready returns to 1 one cycle after the first issue.
REQ-040 SKID=1, occupancy=2, flush=1 with out_ready=0 -> next cycle occupancy=0, out_valid=0, drop_cnt=2.
REQ-041 SKID=1, occupancy=1, flush=1 with a same-cycle accept and an issue -> drop_cnt increases by 1 and the issued entry is observed downstream.
REQ-042 CNT_W=2: four flushes each dropping one entry -> drop_cnt reads 1, 2, 3, 3 (saturates).
REQ-043 SKID=0: random in_valid/out_ready over 10k cycles against a reference queue -> in-order delivery with no loss, and occupancy never exceeds 1.
